unidec_param: RTL and testbench

UNIDEC_PARAM -- requirements
Module: unidec_param

---
 rtl/unidec_param.sv | 133 +++++++++++++
 tb/tb_unidec_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/unidec_param.sv
// unidec_param: nondeterministic step engine for the Sardinas-Patterson
// unique-decipherability test over a small loadable table of code words.
// The table is written while idle. During a check, sel1 chooses the code
// word that the dangling suffix is compared with, and sel2 chooses the
// prefix length. The search reports FOUND when a nonempty dangling suffix
// equals a code word. It reports TRAP when no prefix rule applies.
module unidec_param #(
    parameter int NWORDS = 8,
    parameter int MAXLEN = 6,
    parameter int CNTW   = 8,
    localparam int SELW  = $clog2(NWORDS),
    localparam int LENW  = $clog2(MAXLEN + 1),
    localparam int WW    = MAXLEN + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [SELW-1:0] load_idx,
    input  logic [WW-1:0]   load_code,
    input  logic            start,
    input  logic            abort,
    input  logic [SELW-1:0] sel1,
    input  logic [LENW-1:0] sel2,
    output logic            busy,
    output logic            found,
    output logic            trapped,
    output logic [WW-1:0]   word,
    output logic [CNTW-1:0] step_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FOUND, TRAP} state_t;

    state_t          state, state_nx;
    logic [WW-1:0]   word_nx;
    logic            first, first_nx;
    logic [CNTW-1:0] cnt_nx;
    logic [WW-1:0]   tbl [NWORDS];
    logic [WW-1:0]   other;

    // Word length is the position of the stop bit, which is the highest set bit.
    // A zero word reports length 0. That is safe because every prefix test
    // requires the length to exceed k, and k is at least 1.
    function automatic logic [LENW-1:0] word_len(input logic [WW-1:0] x);
        logic [LENW-1:0] len;
        len = '0;
        for (int i = 0; i < WW; i++) begin
            if (x[i]) len = LENW'(i);
        end
        return len;
    endfunction

    // A prefix of length k exists only for 1 <= k <= MAXLEN-1 and only when
    // x is strictly longer than k.
    function automatic logic prefix_ok(input logic [WW-1:0] x, input logic [LENW-1:0] k);
        return (k != '0) && (int'(k) <= MAXLEN - 1) && (word_len(x) > k);
    endfunction

    // The prefix keeps the low k characters and places a fresh stop bit at position k.
    function automatic logic [WW-1:0] prefix_val(input logic [WW-1:0] x, input logic [LENW-1:0] k);
        logic [WW-1:0] stop;
        stop = WW'(1) << k;
        return stop | (x & (stop - WW'(1)));
    endfunction

    assign other   = tbl[sel1];
    assign busy    = (state == RUN);
    assign found   = (state == FOUND);
    assign trapped = (state == TRAP);

    // Code table: writes are accepted only while idle, and reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) tbl[i] <= '0;
        end else if (state == IDLE && load_en) begin
            tbl[load_idx] <= load_code;
        end
    end

    // Next-state logic. Abort overrides everything but leaves the counter as it is.
    always_comb begin
        state_nx = state;
        word_nx  = word;
        first_nx = first;
        cnt_nx   = step_cnt;
        case (state)
            IDLE, FOUND, TRAP: begin
                if (start) begin
                    state_nx = RUN;
                    word_nx  = other;
                    first_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx   = (&step_cnt) ? step_cnt : step_cnt + CNTW'(1);
                first_nx = 1'b0;
                if (!first && word == other && word != '0) begin
                    state_nx = FOUND;
                end else if (prefix_ok(word, sel2) && prefix_val(word, sel2) == other) begin
                    word_nx = word >> sel2;
                end else if (prefix_ok(other, sel2) && prefix_val(other, sel2) == word) begin
                    word_nx = other >> sel2;
                end else begin
                    word_nx  = '0;
                    state_nx = TRAP;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            word_nx  = '0;
            first_nx = 1'b0;
            cnt_nx   = step_cnt;
        end
    end

    // State, suffix, first-cycle flag and step counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            word     <= '0;
            first    <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_nx;
            word     <= word_nx;
            first    <= first_nx;
            step_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_unidec_param.sv
// tb_unidec_param: directed and random stimulus for unidec_param. The bench
// compares every output on every cycle with an arithmetic reference model.
module tb_unidec_param;

    localparam int NWORDS = 8;
    localparam int MAXLEN = 6;
    localparam int S_IDLE = 0, S_RUN = 1, S_FOUND = 2, S_TRAP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] load_idx = '0;
    logic [6:0] load_code = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] sel1 = '0;
    logic [2:0] sel2 = '0;
    logic       busy, found, trapped;
    logic [6:0] word;
    logic [7:0] step_cnt;

    int compared = 0;
    int mismatched = 0;

    int m_state = S_IDLE;
    int m_word = 0;
    int m_first = 0;
    int m_cnt = 0;
    int m_table [NWORDS];

    unidec_param dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
        .load_code(load_code), .start(start), .abort(abort), .sel1(sel1),
        .sel2(sel2), .busy(busy), .found(found), .trapped(trapped),
        .word(word), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Length of an encoded word in characters. The empty/trap value 0 has no length.
    function automatic int code_len(input int x);
        if (x == 0) return -1;
        return $clog2(x + 1) - 1;
    endfunction

    function automatic bit pre_ok(input int x, input int k);
        return (k >= 1) && (k <= MAXLEN - 1) && (code_len(x) > k);
    endfunction

    function automatic int pre_val(input int x, input int k);
        return (1 << k) + (x % (1 << k));
    endfunction

    // Advance the reference model with the inputs that were sampled at this edge.
    task automatic model_step();
        int  other;
        bit  wr;
        int  k;
        other = m_table[sel1];
        k = int'(sel2);
        if (!rst_n) begin
            m_state = S_IDLE; m_word = 0; m_first = 0; m_cnt = 0;
            for (int i = 0; i < NWORDS; i++) m_table[i] = 0;
            return;
        end
        wr = (m_state == S_IDLE) && load_en;
        if (abort) begin
            m_state = S_IDLE; m_word = 0; m_first = 0;
        end else if (m_state == S_RUN) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (m_first == 0 && m_word == other && m_word != 0) begin
                m_state = S_FOUND;
            end else if (pre_ok(m_word, k) && pre_val(m_word, k) == other) begin
                m_word = m_word / (1 << k);
            end else if (pre_ok(other, k) && pre_val(other, k) == m_word) begin
                m_word = other / (1 << k);
            end else begin
                m_word = 0; m_state = S_TRAP;
            end
            m_first = 0;
        end else if (start) begin
            m_state = S_RUN; m_word = other; m_first = 1; m_cnt = 0;
        end
        if (wr) m_table[load_idx] = int'(load_code);
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_output();
        check_value("busy",     32'(busy),     32'(m_state == S_RUN));
        check_value("found",    32'(found),    32'(m_state == S_FOUND));
        check_value("trapped",  32'(trapped),  32'(m_state == S_TRAP));
        check_value("word",     32'(word),     32'(m_word));
        check_value("step_cnt", 32'(step_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, then clock the edge and compare against the model.
    task automatic apply_stimulus(input logic r, input logic ld, input int idx, input int code,
                                  input logic st, input logic ab, input int s1, input int s2);
        rst_n = r; load_en = ld; load_idx = 3'(idx); load_code = 7'(code);
        start = st; abort = ab; sel1 = 3'(s1); sel2 = 3'(s2);
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic run_step(input int s1, input int s2);
        apply_stimulus(1, 0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin
        int len;
        int code;
        for (int i = 0; i < NWORDS; i++) m_table[i] = 0;

        // Reset
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 5, 1, 0, 0, 0);
        check_value("reset_word", 32'(word), 32'h0);

        // Non-UD detection on {0, 01, 10}
        apply_stimulus(1, 1, 0, 7'b0000010, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 7'b0000110, 0, 0, 0, 0);
        apply_stimulus(1, 1, 2, 7'b0000101, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        check_value("nud_start_word", 32'(word), 32'h06);
        run_step(0, 1);
        check_value("nud_step1_word", 32'(word), 32'h03);
        run_step(2, 1);
        check_value("nud_step2_word", 32'(word), 32'h02);
        run_step(0, 1);
        check_value("nud_found", 32'(found), 32'h1);
        check_value("nud_cnt", 32'(step_cnt), 32'd3);
        run_step(5, 3);
        check_value("nud_hold_word", 32'(word), 32'h02);
        apply_stimulus(1, 0, 0, 0, 1, 1, 1, 0);
        check_value("abort_word", 32'(word), 32'h0);

        // Trap, then restarts from TRAP
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        run_step(2, 1);
        check_value("trap_flag", 32'(trapped), 32'h1);
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        run_step(0, 1);
        check_value("first_guard_found", 32'(found), 32'h0);
        check_value("first_guard_trap", 32'(trapped), 32'h1);
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        run_step(0, 0);
        check_value("k0_trap", 32'(trapped), 32'h1);
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        run_step(0, MAXLEN);
        check_value("kmax_trap", 32'(trapped), 32'h1);
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        run_step(7, 1);
        check_value("empty_trap", 32'(trapped), 32'h1);

        // load_en during RUN is ignored
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        apply_stimulus(1, 1, 0, 7'b0001111, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        check_value("run_load_ignored", 32'(word), 32'h02);
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);

        // Load and start together: start sees the old entry
        apply_stimulus(1, 1, 1, 7'b0000100, 1, 0, 1, 0);
        check_value("load_start_old", 32'(word), 32'h06);
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);

        // Saturation: "0" against "00" loops forever
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) run_step(1, 1);
        check_value("sat_cnt", 32'(step_cnt), 32'd255);
        check_value("sat_busy", 32'(busy), 32'h1);

        // Reset mid-RUN clears the table
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1);
        check_value("midrst_cnt", 32'(step_cnt), 32'h0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        check_value("midrst_table", 32'(word), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            len  = $urandom_range(0, MAXLEN);
            code = ($urandom_range(0, 7) == 0) ? 0 : ((1 << len) | int'($urandom % (1 << len)));
            apply_stimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                           $urandom_range(0, 7), code, ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 24) == 0), $urandom_range(0, 7),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
